subneg_sequencer: RTL

- Control sequencer for the SUBNEG one-instruction processor. Executes `mem[B] = mem[B] - mem[A]; if result < 0 then PC = C else PC = PC + 3`.
- Fetches the three operand words A, B, C from instruction ROM at PC, PC+1, PC+2.
- Reads the data operands through a req/ack data-memory port and drives the datapath strobes: op1/op2 register load, memory write, PC select/load.
- Sits directly upstream of the datapath registers, subtractor and PC mux, and consumes the subtractor's neg flag.

---
 rtl/subneg_sequencer_if.sv | 31 +++
 rtl/subneg_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/subneg_sequencer_if.sv
// rtl/subneg_sequencer_if.sv - ROM, data-memory and datapath strobe bundle for the SUBNEG sequencer
interface subneg_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [ADDR_W-1:0] rom_data;
    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_ack;
    logic              write_op1;
    logic              write_op2;
    logic              write_mem;
    logic              neg;
    logic              sel_pc;
    logic [ADDR_W-1:0] pc_next;
    logic              write_pc;

    modport master (
        output rom_req, rom_addr, dmem_req, dmem_addr,
        output write_op1, write_op2, write_mem, sel_pc, pc_next, write_pc,
        input  rom_ack, rom_data, dmem_ack, neg
    );

    modport slave (
        input  rom_req, rom_addr, dmem_req, dmem_addr,
        input  write_op1, write_op2, write_mem, sel_pc, pc_next, write_pc,
        output rom_ack, rom_data, dmem_ack, neg
    );
endinterface

// File: rtl/subneg_sequencer.sv
// rtl/subneg_sequencer.sv - SUBNEG control sequencer; INSTR_COUNT_EN adds a saturating retired-instruction counter
module subneg_sequencer #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   pc_in,
    subneg_sequencer_if.master  bus,
    output logic                halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]         instr_count
`endif
);

    // The sequencer never touches data words; WIDTH only has to describe a real datapath.
    if (WIDTH < 1) begin : g_width_check
        $error("subneg_sequencer: WIDTH must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RD_A,
        RD_B,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [ADDR_W-1:0] a_q, b_q, c_q;
    logic              neg_q;

    logic              rom_req_c;
    logic [ADDR_W-1:0] rom_addr_c;
    logic              dmem_req_c;
    logic [ADDR_W-1:0] dmem_addr_c;
    logic              write_op1_c;
    logic              write_op2_c;
    logic              write_mem_c;
    logic              sel_pc_c;
    logic [ADDR_W-1:0] pc_next_c;
    logic              write_pc_c;
    logic              halted_c;

    // State register, operand capture and sign capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            neg_q <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == FETCH && bus.rom_ack) begin
                case (idx)
                    2'd0:    a_q <= bus.rom_data;
                    2'd1:    b_q <= bus.rom_data;
                    default: c_q <= bus.rom_data;
                endcase
            end
            if (state == EXEC) begin
                neg_q <= bus.neg;
            end
        end
    end

    // Next state and all outputs; strobes are combinational on the ack so zero-wait memory works
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        rom_req_c   = 1'b0;
        rom_addr_c  = '0;
        dmem_req_c  = 1'b0;
        dmem_addr_c = '0;
        write_op1_c = 1'b0;
        write_op2_c = 1'b0;
        write_mem_c = 1'b0;
        sel_pc_c    = 1'b0;
        pc_next_c   = '0;
        write_pc_c  = 1'b0;
        halted_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    idx_n   = 2'd0;
                end
            end
            FETCH: begin
                rom_req_c  = 1'b1;
                rom_addr_c = pc_in + ADDR_W'(idx);
                if (bus.rom_ack) begin
                    if (idx == 2'd2) begin
                        idx_n   = 2'd0;
                        state_n = RD_A;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            RD_A: begin
                dmem_req_c  = 1'b1;
                dmem_addr_c = a_q;
                if (bus.dmem_ack) begin
                    write_op1_c = 1'b1;
                    state_n     = RD_B;
                end
            end
            RD_B: begin
                dmem_req_c  = 1'b1;
                dmem_addr_c = b_q;
                if (bus.dmem_ack) begin
                    write_op2_c = 1'b1;
                    state_n     = EXEC;
                end
            end
            EXEC: begin
                state_n = WB;
            end
            WB: begin
                dmem_req_c  = 1'b1;
                write_mem_c = 1'b1;
                dmem_addr_c = b_q;
                sel_pc_c    = neg_q;
                pc_next_c   = neg_q ? c_q : pc_in + ADDR_W'(3);
                if (bus.dmem_ack) begin
                    write_pc_c = 1'b1;
                    idx_n      = 2'd0;
                    // A taken branch onto itself can never make progress: stop.
                    state_n    = (neg_q && c_q == pc_in) ? HALT : FETCH;
                end
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rom_req   = rom_req_c;
    assign bus.rom_addr  = rom_addr_c;
    assign bus.dmem_req  = dmem_req_c;
    assign bus.dmem_addr = dmem_addr_c;
    assign bus.write_op1 = write_op1_c;
    assign bus.write_op2 = write_op2_c;
    assign bus.write_mem = write_mem_c;
    assign bus.sel_pc    = sel_pc_c;
    assign bus.pc_next   = pc_next_c;
    assign bus.write_pc  = write_pc_c;
    assign halted        = halted_c;

`ifdef INSTR_COUNT_EN
    logic [15:0] count_q;

    // Retired-instruction counter, saturating at all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if (write_pc_c && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`endif

endmodule
